// File: rtl/iter_shift_pkg.sv
// Shared types and constants for the iterative shift sequencer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package iter_shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;
    // Pair-step counter holds amt[3:1]
    localparam int CNT_W  = AMT_W - 1;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ODD  = 2'b01,
        ST_PAIR = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/iter_shift_stage.sv
// One shift/rotate step of 1 or 2 bit positions on the accumulator.
// Latency: combinational.
// Backpressure: none; the controller decides when the result is captured.
module iter_shift_stage
    import iter_shift_pkg::*;
(
    input  logic [DATA_W-1:0] acc,
    input  logic [1:0]        op,
    input  logic              two_step,
    output logic [DATA_W-1:0] res
);

    // Rotates wrap the end bits around, logical shifts fill with zero
    always_comb begin
        res = acc;
        if (two_step) begin
            case (op)
                OP_ROL:  res = {acc[DATA_W-3:0], acc[DATA_W-1:DATA_W-2]};
                OP_SLL:  res = {acc[DATA_W-3:0], 2'b00};
                OP_ROR:  res = {acc[1:0], acc[DATA_W-1:2]};
                default: res = {2'b00, acc[DATA_W-1:2]};
            endcase
        end else begin
            case (op)
                OP_ROL:  res = {acc[DATA_W-2:0], acc[DATA_W-1]};
                OP_SLL:  res = {acc[DATA_W-2:0], 1'b0};
                OP_ROR:  res = {acc[0], acc[DATA_W-1:1]};
                default: res = {1'b0, acc[DATA_W-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Iterative 16-bit rotate/shift sequencer: one 1-bit step for odd amounts, then 2-bit steps.
// Latency: done in cycle 1 + amt[0] + amt[3:1] after start acceptance (1..9 cycles).
// Backpressure: one op in flight; start while busy is dropped. ITER_SHIFT_ABORT_EN adds abort.
module iter_shift_ctrl
    import iter_shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef ITER_SHIFT_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        oper,
    input  logic [AMT_W-1:0]  amt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            r_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out;
    logic [1:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;

    logic              w_two_step;
    logic [DATA_W-1:0] w_step;
    logic              w_abort;

`ifdef ITER_SHIFT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_two_step = (r_state == ST_PAIR);

    iter_shift_stage u_stage (
        .acc      (r_acc),
        .op       (r_op),
        .two_step (w_two_step),
        .res      (w_step)
    );

    // Sequencer: the result register is loaded on the edge entering DONE so it lines up with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_out   <= '0;
            r_op    <= OP_ROL;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc  <= in;
                        r_op   <= oper;
                        r_cnt  <= amt[AMT_W-1:1];
                        r_busy <= 1'b1;
                        if (amt[0]) begin
                            r_state <= ST_ODD;
                        end else if (amt[AMT_W-1:1] != '0) begin
                            r_state <= ST_PAIR;
                        end else begin
                            r_state <= ST_DONE;
                            r_out   <= in;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_ODD: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt != '0) begin
                            r_state <= ST_PAIR;
                        end else begin
                            r_state <= ST_DONE;
                            r_out   <= w_step;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_PAIR: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= ST_DONE;
                            r_out   <= w_step;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Self-checking bench for iter_shift_ctrl: a cycle-level reference model plus directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_iter_shift_ctrl;

    logic        clk;
    logic        s_rst_n;
    logic        s_abort;
    logic        s_start;
    logic [15:0] s_in;
    logic [1:0]  s_oper;
    logic [3:0]  s_amt;
    logic        s_busy;
    logic        s_done;
    logic [15:0] s_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 0;

    iter_shift_ctrl dut (
        .clk   (clk),
        .rst_n (s_rst_n),
`ifdef ITER_SHIFT_ABORT_EN
        .abort (s_abort),
`endif
        .start (s_start),
        .in    (s_in),
        .oper  (s_oper),
        .amt   (s_amt),
        .busy  (s_busy),
        .done  (s_done),
        .out   (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Arithmetic reference for the full-amount result
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] op, input logic [3:0] a);
        int unsigned v;
        int unsigned r;
        int n;
        v = {16'h0, x};
        n = int'(a);
        case (op)
            2'b00:   r = (v << n) | (v >> (16 - n));
            2'b01:   r = v << n;
            2'b10:   r = (v >> n) | (v << (16 - n));
            default: r = v >> n;
        endcase
        return r[15:0];
    endfunction

    // Model: count of busy cycles still to come; done is the last of them
    int          m_rem;
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_out;
    logic [15:0] m_res;

    always @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m_rem  = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = 16'h0;
            m_res  = 16'h0;
        end else begin
            if (m_rem == 0) begin
                if (s_start) begin
                    m_res = ref_shift(s_in, s_oper, s_amt);
                    m_rem = 1 + int'(s_amt) % 2 + int'(s_amt) / 2;
                end
            end else begin
`ifdef ITER_SHIFT_ABORT_EN
                if (s_abort && m_rem > 1) m_rem = 0;
                else m_rem = m_rem - 1;
`else
                m_rem = m_rem - 1;
`endif
            end
            m_busy = (m_rem != 0);
            m_done = (m_rem == 1);
            if (m_done) m_out = m_res;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && s_rst_n) begin
            check("cyc_busy", {31'h0, s_busy}, {31'h0, m_busy});
            check("cyc_done", {31'h0, s_done}, {31'h0, m_done});
            check("cyc_out",  {16'h0, s_out},  {16'h0, m_out});
        end
    end

    // Done pulse counter, sampled on the rising edge before outputs update
    always @(posedge clk) begin
        if (s_done === 1'b1) n_done++;
    end

    // Issue one op from IDLE, then pin result, latency and busy width to literals
    task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] x,
                          input logic [3:0] a, input logic [15:0] exp_out, input int exp_lat);
        int cyc;
        int nb;
        s_start = 1'b1;
        s_oper  = op;
        s_in    = x;
        s_amt   = a;
        @(negedge clk);
        s_start = 1'b0;
        s_in    = 16'($urandom);
        s_oper  = 2'($urandom);
        s_amt   = 4'($urandom);
        cyc = 1;
        nb  = 0;
        while (1) begin
            if (s_busy === 1'b1) nb++;
            if (s_done === 1'b1 || cyc >= 20) break;
            @(negedge clk);
            cyc++;
        end
        check({name, "_lat"},  cyc, exp_lat);
        check({name, "_out"},  {16'h0, s_out}, {16'h0, exp_out});
        check({name, "_busy"}, nb, exp_lat);
        @(negedge clk);
        check({name, "_idle"}, {31'h0, s_busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        s_rst_n = 1'b0;
        s_abort = 1'b0;
        s_start = 1'b0;
        s_in    = 16'h0;
        s_oper  = 2'b00;
        s_amt   = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, s_busy}, 32'h0);
        check("rst_done", {31'h0, s_done}, 32'h0);
        check("rst_out",  {16'h0, s_out},  32'h0);
        s_rst_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results
        run_op("rol5",     2'b00, 16'h8001, 4'd5,  16'h0030, 4);
        run_op("sll15",    2'b01, 16'hFFFF, 4'd15, 16'h8000, 9);
        run_op("ror2",     2'b10, 16'h0003, 4'd2,  16'hC000, 2);
        run_op("srl7",     2'b11, 16'hF000, 4'd7,  16'h01E0, 5);
        run_op("srl0",     2'b11, 16'h1234, 4'd0,  16'h1234, 1);
        run_op("srl15",    2'b11, 16'h8000, 4'd15, 16'h0001, 9);
        run_op("rol4",     2'b00, 16'h1234, 4'd4,  16'h2341, 3);
        run_op("ror12",    2'b10, 16'h1234, 4'd12, 16'h2341, 7);
        run_op("sll8",     2'b01, 16'h00FF, 4'd8,  16'hFF00, 5);
        run_op("srl1",     2'b11, 16'hFFFF, 4'd1,  16'h7FFF, 2);

        // Second start while busy is dropped: exactly one done, first result kept
        d0 = n_done;
        s_start = 1'b1; s_oper = 2'b00; s_in = 16'h1234; s_amt = 4'd15;
        @(negedge clk);
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        s_start = 1'b1; s_oper = 2'b01; s_in = 16'hFFFF; s_amt = 4'd0;
        @(negedge clk);
        s_start = 1'b0;
        repeat (10) @(negedge clk);
        check("ign_ndone", n_done - d0, 1);
        check("ign_out", {16'h0, s_out}, {16'h0, 16'h091A});

        // Start held high: back-to-back ops with one idle cycle between
        d0 = n_done;
        s_start = 1'b1; s_oper = 2'b11; s_in = 16'hFFFF; s_amt = 4'd1;
        repeat (9) @(negedge clk);
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_ndone", n_done - d0, 3);
        check("b2b_out", {16'h0, s_out}, {16'h0, 16'h7FFF});

        // Reset in the middle of a PAIR sequence
        d0 = n_done;
        s_start = 1'b1; s_oper = 2'b00; s_in = 16'h8001; s_amt = 4'd12;
        @(negedge clk);
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        s_rst_n = 1'b0;
        #1;
        check("mrst_busy", {31'h0, s_busy}, 32'h0);
        check("mrst_out",  {16'h0, s_out},  32'h0);
        @(negedge clk);
        s_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mrst_ndone", n_done - d0, 0);
        run_op("post_rst", 2'b00, 16'h8001, 4'd5, 16'h0030, 4);

`ifdef ITER_SHIFT_ABORT_EN
        // Abort in the third cycle of a long shift keeps the previous result
        run_op("pre_abort", 2'b10, 16'h0003, 4'd2, 16'hC000, 2);
        d0 = n_done;
        s_start = 1'b1; s_oper = 2'b01; s_in = 16'hFFFF; s_amt = 4'd15;
        @(negedge clk);
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        s_abort = 1'b1;
        @(negedge clk);
        s_abort = 1'b0;
        check("abort_busy", {31'h0, s_busy}, 32'h0);
        check("abort_done", {31'h0, s_done}, 32'h0);
        check("abort_out",  {16'h0, s_out},  {16'h0, 16'hC000});
        repeat (10) @(negedge clk);
        check("abort_ndone", n_done - d0, 0);
        run_op("post_abort", 2'b11, 16'hF000, 4'd7, 16'h01E0, 5);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
